// File: rtl/sudoku_pkg.sv
// Purpose: shared types, row-word field layout, digit decode and unit/cell table for the 4x4 board.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package sudoku_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } scan_state_t;

   localparam int WP_MSB    = 23;
   localparam int WP_LSB    = 20;
   localparam int BLANK_MSB = 19;
   localparam int BLANK_LSB = 16;
   localparam int DIGIT_W   = 4;
   localparam int N_ROWS    = 4;
   localparam int N_UNITS   = 12;

   localparam logic [3:0] READ_LAST  = 4'd4;
   localparam logic [3:0] CHECK_LAST = 4'd11;

   // Each entry lists the four cells of one unit as nibbles {row[1:0], col[1:0]},
   // cell k of the unit at [4k+3:4k]. Entries 0..3 rows, 4..7 columns, 8..11 boxes.
   localparam logic [15:0] UNIT_CELLS [N_UNITS] = '{
      16'h3210, 16'h7654, 16'hBA98, 16'hFEDC,
      16'hC840, 16'hD951, 16'hEA62, 16'hFB73,
      16'h5410, 16'h7632, 16'hDC98, 16'hFEBA
   };

   // Digit 1..4 maps to one-hot bit (digit-1); anything else contributes nothing.
   function automatic logic [3:0] digit_onehot(input logic [DIGIT_W-1:0] v);
      logic [3:0] oh;
      case (v)
         4'd1:    oh = 4'b0001;
         4'd2:    oh = 4'b0010;
         4'd3:    oh = 4'b0100;
         4'd4:    oh = 4'b1000;
         default: oh = 4'b0000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/sudoku_unit_check.sv
// Purpose: decides whether four digits of one row/column/box are exactly {1,2,3,4}.
// Latency: combinational, 0 cycles.
// Backpressure: none; evaluated every cycle.
module sudoku_unit_check
   import sudoku_pkg::*;
(
   input  logic [4*DIGIT_W-1:0] i_digits,
   output logic                 o_pass
);

   logic [3:0] w_seen;

   // Union of the decoded digits; all four bits set means no digit missing.
   always_comb begin
      w_seen = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         w_seen = w_seen | digit_onehot(i_digits[k*DIGIT_W +: DIGIT_W]);
      end
   end

   assign o_pass = (w_seen == 4'b1111);

endmodule

// File: rtl/board_scan_controller.sv
// Purpose: arbitrates the single-port board RAM between user edits and a background validity scan.
// Latency: edit granted in the request cycle; scan result 19 edges after the launching IDLE cycle.
// Backpressure: an edit always wins and aborts any scan; the scan restarts once edits stop.
module board_scan_controller
   import sudoku_pkg::*;
(
   input  logic        CLK,
   input  logic        RST_N,
   output logic [1:0]  RamAddr,
   output logic        RamWe,
   output logic [23:0] RamWrDat,
   input  logic [23:0] RamDat,
   input  logic        edit_req,
   input  logic [1:0]  edit_addr,
   input  logic [23:0] edit_data,
   output logic        edit_gnt,
   output logic        scan_busy,
   output logic        scan_done,
   output logic        gameComplete
);

   scan_state_t r_state, w_state_nxt;
   logic [3:0]  r_cnt, w_cnt_nxt;
   logic [23:0] r_snap [N_ROWS];
   logic        r_dirty;
   logic        r_ok;
   logic        r_scan_done;
   logic        r_game_complete;

   logic        w_edit;
   logic [3:0]  w_cells [16];
   logic [3:0]  w_unit;
   logic [15:0] w_unit_cells;
   logic [15:0] w_unit_digits;
   logic        w_unit_pass;
   logic [1:0]  w_snap_idx;
   logic [3:0]  w_blank_any;

   // An edit seen while reset is held must not reach the RAM.
   assign w_edit       = edit_req & RST_N;
   assign RamWrDat     = edit_data;
   assign scan_busy    = (r_state != ST_IDLE);
   assign scan_done    = r_scan_done;
   assign gameComplete = r_game_complete;

   // Data for address r arrives one cycle later, so READ step r fills row r-1.
   assign w_snap_idx   = r_cnt[1:0] - 2'd1;
   assign w_blank_any  = r_snap[0][BLANK_MSB:BLANK_LSB] | r_snap[1][BLANK_MSB:BLANK_LSB]
                       | r_snap[2][BLANK_MSB:BLANK_LSB] | r_snap[3][BLANK_MSB:BLANK_LSB];
   assign w_unit       = (r_state == ST_CHECK) ? r_cnt : 4'd0;
   assign w_unit_cells = UNIT_CELLS[w_unit];

   // Flatten the snapshot into a cell array indexed by {row, col}.
   always_comb begin
      for (int r = 0; r < N_ROWS; r++) begin
         for (int c = 0; c < 4; c++) begin
            w_cells[r*4 + c] = r_snap[r][c*DIGIT_W +: DIGIT_W];
         end
      end
   end

   // Gather the four digits of the unit currently being checked.
   always_comb begin
      w_unit_digits = '0;
      for (int k = 0; k < 4; k++) begin
         w_unit_digits[k*DIGIT_W +: DIGIT_W] = w_cells[w_unit_cells[k*4 +: 4]];
      end
   end

   sudoku_unit_check u_unit_check (
      .i_digits (w_unit_digits),
      .o_pass   (w_unit_pass)
   );

   // State and step-counter register.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next state, step counter and RAM port mux; an edit overrides everything.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      RamWe       = 1'b0;
      RamAddr     = 2'd0;
      edit_gnt    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_dirty) begin
               w_state_nxt = ST_READ;
               w_cnt_nxt   = 4'd0;
            end
         end
         ST_READ: begin
            if (r_cnt == READ_LAST) begin
               w_state_nxt = ST_CHECK;
               w_cnt_nxt   = 4'd0;
            end else begin
               RamAddr   = r_cnt[1:0];
               w_cnt_nxt = r_cnt + 4'd1;
            end
         end
         ST_CHECK: begin
            if (r_cnt == CHECK_LAST) begin
               w_state_nxt = ST_DONE;
               w_cnt_nxt   = 4'd0;
            end else begin
               w_cnt_nxt = r_cnt + 4'd1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 4'd0;
         end
      endcase
      if (w_edit) begin
         RamWe       = 1'b1;
         RamAddr     = edit_addr;
         edit_gnt    = 1'b1;
         w_state_nxt = ST_IDLE;
         w_cnt_nxt   = 4'd0;
      end
   end

   // Snapshot capture, unit accumulation, dirty tracking and the published result.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_dirty         <= 1'b1;
         r_ok            <= 1'b0;
         r_scan_done     <= 1'b0;
         r_game_complete <= 1'b0;
         for (int r = 0; r < N_ROWS; r++) begin
            r_snap[r] <= 24'd0;
         end
      end else begin
         r_scan_done <= 1'b0;
         if (w_edit) begin
            r_dirty         <= 1'b1;
            r_game_complete <= 1'b0;
         end else begin
            case (r_state)
               ST_READ: begin
                  if (r_cnt != 4'd0) begin
                     r_snap[w_snap_idx] <= RamDat;
                  end
                  if (r_cnt == READ_LAST) begin
                     r_ok <= 1'b1;
                  end
               end
               ST_CHECK: begin
                  r_ok <= r_ok & w_unit_pass;
               end
               ST_DONE: begin
                  r_game_complete <= r_ok & ~(|w_blank_any);
                  r_scan_done     <= 1'b1;
                  r_dirty         <= 1'b0;
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_board_scan_controller.sv
// Purpose: directed plus randomized board checks of board_scan_controller against a rule-level model.
// Latency: expects scan results 19 edges after the launching IDLE cycle, edit grant in the same cycle.
// Backpressure: edits are injected at chosen scan steps to exercise abort and restart.
module tb_board_scan_controller;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic [1:0]  RamAddr;
   logic        RamWe;
   logic [23:0] RamWrDat;
   logic [23:0] RamDat;
   logic        edit_req;
   logic [1:0]  edit_addr;
   logic [23:0] edit_data;
   logic        edit_gnt;
   logic        scan_busy;
   logic        scan_done;
   logic        gameComplete;

   logic [23:0] mem   [4];
   logic [23:0] model [4];
   logic [23:0] nb    [4];
   logic        ld_en;
   logic [1:0]  ld_addr;
   logic [23:0] ld_dat;

   int total = 0;
   int bad   = 0;

   int base [4][4] = '{'{1, 2, 3, 4}, '{3, 4, 1, 2}, '{2, 1, 4, 3}, '{4, 3, 2, 1}};

   board_scan_controller dut (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .RamAddr      (RamAddr),
      .RamWe        (RamWe),
      .RamWrDat     (RamWrDat),
      .RamDat       (RamDat),
      .edit_req     (edit_req),
      .edit_addr    (edit_addr),
      .edit_data    (edit_data),
      .edit_gnt     (edit_gnt),
      .scan_busy    (scan_busy),
      .scan_done    (scan_done),
      .gameComplete (gameComplete)
   );

   always #5 CLK = ~CLK;

   // Synchronous single-port RAM with a bench-side preload port.
   always @(posedge CLK) begin
      if (ld_en) mem[ld_addr] <= ld_dat;
      else if (RamWe) mem[RamAddr] <= RamWrDat;
      RamDat <= mem[RamAddr];
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Board is complete iff no blank flags and every row, column and box holds exactly 1..4.
   function automatic bit ref_complete();
      bit          ok;
      logic [3:0]  seen;
      logic [23:0] w;
      int          row, col, b, v;
      ok = 1'b1;
      for (int r = 0; r < 4; r++) begin
         w = model[r] >> 16;
         if (w[3:0] != 4'd0) ok = 1'b0;
      end
      for (int u = 0; u < 12; u++) begin
         seen = 4'd0;
         for (int k = 0; k < 4; k++) begin
            if (u < 4) begin
               row = u; col = k;
            end else if (u < 8) begin
               row = k; col = u - 4;
            end else begin
               b = u - 8;
               row = 2 * (b / 2) + k / 2;
               col = 2 * (b % 2) + k % 2;
            end
            w = model[row] >> (4 * col);
            v = int'(w[3:0]);
            if (v >= 1 && v <= 4) seen[v-1] = 1'b1;
         end
         if (seen != 4'hF) ok = 1'b0;
      end
      return ok;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic load_row(input logic [1:0] a, input logic [23:0] d);
      ld_en = 1'b1; ld_addr = a; ld_dat = d;
      model[a] = d;
      tick();
      ld_en = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_addr"},  32'(RamAddr),      32'd0);
      check({tag, "_we"},    32'(RamWe),        32'd0);
      check({tag, "_gnt"},   32'(edit_gnt),     32'd0);
      check({tag, "_busy"},  32'(scan_busy),    32'd0);
      check({tag, "_done"},  32'(scan_done),    32'd0);
      check({tag, "_gc"},    32'(gameComplete), 32'd0);
   endtask

   // Drive one edit cycle, check the same-cycle grant, then the cleared result after the edge.
   task automatic edit_row(input logic [1:0] a, input logic [23:0] d);
      edit_req = 1'b1; edit_addr = a; edit_data = d;
      #1;
      check("edit_gnt",   32'(edit_gnt), 32'd1);
      check("edit_we",    32'(RamWe),    32'd1);
      check("edit_addr",  32'(RamAddr),  32'(a));
      check("edit_wrdat", 32'(RamWrDat), 32'(d));
      model[a] = d;
      @(posedge CLK);
      #1;
      edit_req = 1'b0;
      check("edit_gc_clr",   32'(gameComplete), 32'd0);
      check("edit_no_done",  32'(scan_done),    32'd0);
   endtask

   // Called in the launching IDLE cycle; expects the result on the 19th edge.
   task automatic wait_done(input string tag, input bit exp_gc);
      int n;
      bit seen;
      n = 0; seen = 1'b0;
      while (n < 60 && !seen) begin
         tick();
         n++;
         if (n == 1) check({tag, "_busy_start"}, 32'(scan_busy), 32'd1);
         if (scan_done) seen = 1'b1;
      end
      check({tag, "_done_seen"}, 32'(seen),         32'd1);
      check({tag, "_latency"},   32'(n),            32'd19);
      check({tag, "_gc"},        32'(gameComplete), 32'(exp_gc));
      check({tag, "_idle"},      32'(scan_busy),    32'd0);
      tick();
      check({tag, "_pulse"},     32'(scan_done),    32'd0);
      check({tag, "_gc_hold"},   32'(gameComplete), 32'(exp_gc));
   endtask

   // Random valid board by relabelling digits and permuting bands/rows/columns, optionally corrupted.
   task automatic gen_board();
      int perm [4];
      int ro [4];
      int co [4];
      int t, j, b, s0, s1, mode, cr, cc;
      int g [4][4];
      for (int i = 0; i < 4; i++) perm[i] = i + 1;
      for (int i = 3; i > 0; i--) begin
         j = int'($urandom_range(0, i));
         t = perm[i]; perm[i] = perm[j]; perm[j] = t;
      end
      b = int'($urandom_range(0, 1)); s0 = int'($urandom_range(0, 1)); s1 = int'($urandom_range(0, 1));
      ro[0] = 2*b + s0; ro[1] = 2*b + 1 - s0; ro[2] = 2*(1-b) + s1; ro[3] = 2*(1-b) + 1 - s1;
      b = int'($urandom_range(0, 1)); s0 = int'($urandom_range(0, 1)); s1 = int'($urandom_range(0, 1));
      co[0] = 2*b + s0; co[1] = 2*b + 1 - s0; co[2] = 2*(1-b) + s1; co[3] = 2*(1-b) + 1 - s1;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            g[r][c] = perm[base[ro[r]][co[c]] - 1];
      mode = int'($urandom_range(0, 3));
      cr = int'($urandom_range(0, 3));
      cc = int'($urandom_range(0, 3));
      if (mode == 0) g[cr][cc] = int'($urandom_range(0, 7));
      for (int r = 0; r < 4; r++) begin
         nb[r] = 24'd0;
         for (int c = 0; c < 4; c++) nb[r][4*c +: 4] = 4'(g[r][c]);
         nb[r][23:20] = 4'($urandom_range(0, 15));
      end
      if (mode == 1) nb[cr][16 + cc] = 1'b1;
   endtask

   initial begin
      int k;
      logic [1:0] ra;
      RST_N = 1'b0; edit_req = 1'b0; edit_addr = 2'd0; edit_data = 24'd0;
      ld_en = 1'b0; ld_addr = 2'd0; ld_dat = 24'd0;
      ticks(2);
      load_row(2'd0, 24'h004321);
      load_row(2'd1, 24'h002143);
      load_row(2'd2, 24'h003412);
      load_row(2'd3, 24'h001234);
      check_reset_outputs("reset");

      // Automatic scan after reset of a valid board.
      RST_N = 1'b1;
      wait_done("valid", 1'b1);

      // Every row is 1..4 but columns repeat.
      for (int r = 0; r < 4; r++) edit_row(2'(r), 24'h004321);
      wait_done("rows_only", 1'b0);

      // Valid digits with a blank flag on row 2, then cleared.
      edit_row(2'd1, 24'h002143);
      edit_row(2'd2, 24'h013412);
      edit_row(2'd3, 24'h001234);
      wait_done("blank", 1'b0);
      edit_row(2'd2, 24'h003412);
      wait_done("blank_fixed", 1'b1);

      // Edit at READ step 2 aborts and restarts the scan.
      edit_row(2'd0, 24'h004321);
      ticks(3);
      check("read2_busy", 32'(scan_busy), 32'd1);
      edit_row(2'd0, 24'h004321);
      wait_done("edit_read2", 1'b1);

      // Edit in the DONE cycle suppresses the result and forces a rescan.
      edit_row(2'd1, 24'h002143);
      ticks(18);
      check("done_busy", 32'(scan_busy), 32'd1);
      edit_row(2'd1, 24'h002143);
      wait_done("edit_done", 1'b1);

      // Out-of-range digits 0 and 5.
      edit_row(2'd3, 24'h001230);
      wait_done("digit0", 1'b0);
      edit_row(2'd3, 24'h001534);
      wait_done("digit5", 1'b0);
      edit_row(2'd3, 24'h001234);
      wait_done("restored", 1'b1);

      // One-cycle reset in the middle of CHECK.
      edit_row(2'd0, 24'h004321);
      ticks(10);
      RST_N = 1'b0;
      tick();
      check_reset_outputs("mid_rst");
      RST_N = 1'b1;
      wait_done("post_rst", 1'b1);

      // Randomized boards with an optional edit injected at a random scan step.
      for (int it = 0; it < 25; it++) begin
         gen_board();
         for (int r = 0; r < 4; r++) edit_row(2'(r), nb[r]);
         k = int'($urandom_range(0, 25));
         if (k < 19) begin
            ticks(k);
            if (k > 0) check("rnd_busy", 32'(scan_busy), 32'd1);
            ra = 2'($urandom_range(0, 3));
            edit_row(ra, nb[ra]);
         end
         wait_done("rnd", ref_complete());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/board_scan_controller.md
# board_scan_controller

Sequences all accesses to the single-port 4x4 Sudoku game RAM (four 24-bit row words). User edit writes have absolute priority. When the board is dirty, the block runs a background scan: it reads all four rows, then checks 4 rows, 4 columns and 4 2x2 boxes, one unit per cycle. It owns the RAM address and write-enable mux and produces the registered game-complete flag used by the win display.

## Interface
- Parameters: none. Geometry is fixed at 4x4 with a 2-bit row address.
- CLK  in  1  system clock; all logic on posedge.
- RST_N  in  1  reset, synchronous, active-low.
- RamAddr  out  2  RAM row address.
- RamWe  out  1  RAM write enable.
- RamWrDat  out  24  RAM write data; equals edit_data.
- RamDat  in  24  RAM read data.
  - [23:20] write-protect, [19:16] blank flags, [15:0] digits.
  - Digit c (0..3) sits at [4c+3:4c].
- edit_req  in  1  user write request; held until granted.
- edit_addr  in  2  row to write.
- edit_data  in  24  full row word to write.
- edit_gnt  out  1  write performed this cycle (Mealy).
- scan_busy  out  1  high in READ, CHECK and DONE.
- scan_done  out  1  one-cycle pulse when gameComplete is updated.
- gameComplete  out  1  last completed scan found a full valid board.

## Operation
- RAM is synchronous: the address driven in cycle t returns data on RamDat in cycle t+1.
- States:
  - IDLE: leave for READ when dirty=1 and edit_req=0.
  - READ: 5 cycles, r=0..4. Issue address r for r<4. Capture RamDat into snapshot[r-1] for r>=1. Then go to CHECK.
  - CHECK: 12 cycles, u=0..11.
    - u 0..3: row u.
    - u 4..7: column u-4 (digit u-4 of each row).
    - u 8..11: box b=u-8, covering rows 2(b>>1) and 2(b>>1)+1, digits 2(b&1) and 2(b&1)+1.
    - Unit passes iff the OR of the four decoded digits is 4'b1111.
    - Decode: value 1..4 gives one-hot bit value-1; any other value gives 0.
    - ok accumulator: set to 1 on CHECK entry, then ANDed with each unit result.
  - DONE: 1 cycle. gameComplete <= ok AND no blank bit set in any snapshot word. Pulse scan_done, clear dirty, go to IDLE.
- Edit arbitration: edit_req=1 in any state makes that cycle a write cycle.
  - RamWe=1, RamAddr=edit_addr, edit_gnt=1.
  - Any scan in progress is aborted; next state is IDLE.
  - dirty <= 1; gameComplete <= 0; no scan_done.
- When not writing: RamWe=0, and RamAddr is the scan address or 0.
- Continuous edit_req starves scanning. This is acceptable and the user path guarantees it does not happen.
- Write-protect bits are stored and scanned but not enforced here; the edit source enforces them.

## Timing
- Reset values: RamAddr=0, RamWe=0, edit_gnt=0, scan_busy=0, scan_done=0, gameComplete=0. State=IDLE, dirty=1, snapshot cleared.
- A scan starts automatically after reset.
- Scan length is 18 cycles (5 READ + 12 CHECK + 1 DONE).
- gameComplete and scan_done become visible on the 19th edge after the IDLE cycle that launched the scan.
- Edit latency: 0 cycles; edit_gnt is asserted in the same cycle as edit_req.
- Edit in the DONE cycle: the edit wins, gameComplete=0, scan_done=0, and a rescan follows.
- Edit in the cycle IDLE would launch a scan: the write happens and the block stays IDLE. The scan launches the next cycle with no edit_req.
- Reset mid-scan returns to reset values; the snapshot is discarded.

## Structure
- Shared package sudoku_pkg holds:
  - the state enum;
  - word-field constants: WP_MSB/LSB, BLANK_MSB/LSB, DIGIT_W=4;
  - the digit one-hot decode function;
  - a unit-to-cell index table for rows, columns and boxes.
- One natural sub-module: sudoku_unit_check. It is combinational: it takes four 4-bit digits and outputs pass.
- The top-level module holds the FSM, counters, snapshot buffer and arbitration mux.

## Test plan
- Valid board: rows 24'h004321, 24'h002143, 24'h003412, 24'h001234. After reset, gameComplete=1 and scan_done pulses 19 cycles after the first IDLE cycle.
- Rows pass, columns fail: all rows 24'h004321. Requires gameComplete=0 after the scan.
- Blank flag: valid board with row 2 = 24'h013412. Requires gameComplete=0.
- Edit at READ r=2: edit_gnt=1, RamWe=1 and RamAddr=edit_addr the same cycle. gameComplete=0, scan restarts, and the result follows 19 cycles after the next IDLE.
- Invalid digits: a board containing 0 or 5 requires gameComplete=0.
- RST_N low for 1 cycle mid-CHECK: all outputs go to reset values, then a full rescan reproduces the prior result.
